// File: rtl/ofifo_row_align_pkg.sv
// Shared sizing for the row-aligned output FIFO between the MAC columns and the SFU.
package ofifo_row_align_pkg;
    localparam int PSUM_BW     = 16;
    localparam int COL         = 8;
    localparam int OFIFO_DEPTH = 64;

    // Extra wrap bit above the index lets equal indices mean either empty or full.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction
endpackage

// File: rtl/ofifo_lane.sv
// One column's FIFO lane: storage, wrap-bit pointers, empty/full and sticky overflow.
module ofifo_lane
    import ofifo_row_align_pkg::*;
#(
    parameter int W     = PSUM_BW,
    parameter int DEPTH = OFIFO_DEPTH
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         wr,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         empty,
    output logic         full,
    output logic         ovf
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = ptr_width(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic          r_ovf;
    logic          w_wr_en;

    assign empty   = (r_wr_ptr == r_rd_ptr);
    assign full    = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
    assign w_wr_en = wr & ~full;
    assign dout    = r_mem[r_rd_ptr[AW-1:0]];
    assign ovf     = r_ovf;

    // Storage is intentionally left uninitialised on reset.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (wr && full) begin
                r_ovf <= 1'b1;
            end
        end
    end
endmodule

// File: rtl/ofifo_row_align.sv
// Output FIFO: independent per-column writes, row-aligned first-word-fall-through pops.
module ofifo_row_align
    import ofifo_row_align_pkg::*;
#(
    parameter int psum_bw = PSUM_BW,
    parameter int col     = COL,
    parameter int DEPTH   = OFIFO_DEPTH
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [col-1:0]         wr,
    input  logic [psum_bw*col-1:0] in,
    input  logic                   rd,
    output logic [psum_bw*col-1:0] out,
    output logic                   o_valid,
    output logic                   o_ready,
    output logic                   o_full,
    output logic [col-1:0]         o_ovf,
    output logic                   o_udf
);
    logic [col-1:0] w_empty;
    logic [col-1:0] w_full;
    logic           w_pop;
    logic           r_udf;

    // A pop only happens when every lane has a head, so lanes never drift out of row alignment.
    assign w_pop = rd & o_valid;

    for (genvar g = 0; g < col; g++) begin : g_lane
        ofifo_lane #(
            .W     (psum_bw),
            .DEPTH (DEPTH)
        ) u_lane (
            .clk     (clk),
            .reset_n (reset_n),
            .wr      (wr[g]),
            .din     (in[psum_bw*g +: psum_bw]),
            .pop     (w_pop),
            .dout    (out[psum_bw*g +: psum_bw]),
            .empty   (w_empty[g]),
            .full    (w_full[g]),
            .ovf     (o_ovf[g])
        );
    end

    assign o_valid = &(~w_empty);
    assign o_full  = |w_full;
    assign o_ready = ~o_full;
    assign o_udf   = r_udf;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_udf <= 1'b0;
        end else if (rd && !o_valid) begin
            r_udf <= 1'b1;
        end
    end
endmodule

// File: tb/tb_ofifo_row_align.sv
// Self-checking bench for ofifo_row_align using per-lane scoreboard queues.
module tb_ofifo_row_align;
    localparam int W = 16;
    localparam int C = 8;
    localparam int D = 64;

    logic           clk;
    logic           reset_n;
    logic [C-1:0]   wr_v;
    logic [W*C-1:0] din_v;
    logic           rd_v;
    logic [W*C-1:0] out_v;
    logic           o_valid;
    logic           o_ready;
    logic           o_full;
    logic [C-1:0]   o_ovf;
    logic           o_udf;

    logic [W-1:0] mq [C][$];
    logic [C-1:0] ovf_m;
    logic         udf_m;
    int           n_chk;
    int           n_pass;

    ofifo_row_align dut (
        .clk     (clk),
        .reset_n (reset_n),
        .wr      (wr_v),
        .in      (din_v),
        .rd      (rd_v),
        .out     (out_v),
        .o_valid (o_valid),
        .o_ready (o_ready),
        .o_full  (o_full),
        .o_ovf   (o_ovf),
        .o_udf   (o_udf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W*C-1:0] obs, input logic [W*C-1:0] exp_v);
        n_chk++;
        if (obs === exp_v) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    endtask

    task automatic model_clear();
        for (int g = 0; g < C; g++) mq[g].delete();
        ovf_m = '0;
        udf_m = 1'b0;
    endtask

    // Called at a negedge: drive, check pre-edge view, update model, step to next negedge.
    task automatic do_cycle(input logic [C-1:0] w, input logic [W*C-1:0] d, input logic r);
        logic           mv;
        logic           any_full;
        logic [C-1:0]   fpre;
        logic [W*C-1:0] exp_row;
        wr_v  = w;
        din_v = d;
        rd_v  = r;
        #1;
        mv = 1'b1;
        any_full = 1'b0;
        exp_row = '0;
        for (int g = 0; g < C; g++) begin
            fpre[g] = (mq[g].size() == D);
            if (mq[g].size() == 0) mv = 1'b0;
            if (fpre[g]) any_full = 1'b1;
        end
        chk("valid", {127'd0, o_valid}, {127'd0, mv});
        chk("full", {127'd0, o_full}, {127'd0, any_full});
        chk("ready", {127'd0, o_ready}, {127'd0, ~any_full});
        if (mv) begin
            for (int g = 0; g < C; g++) exp_row[W*g +: W] = mq[g][0];
            chk("row", out_v, exp_row);
        end
        if (r) begin
            if (mv) begin
                for (int g = 0; g < C; g++) void'(mq[g].pop_front());
            end else begin
                udf_m = 1'b1;
            end
        end
        for (int g = 0; g < C; g++) begin
            if (w[g]) begin
                if (fpre[g]) ovf_m[g] = 1'b1;
                else mq[g].push_back(d[W*g +: W]);
            end
        end
        @(negedge clk);
        wr_v = '0;
        rd_v = 1'b0;
        #1;
        chk("ovf", {120'd0, o_ovf}, {120'd0, ovf_m});
        chk("udf", {127'd0, o_udf}, {127'd0, udf_m});
    endtask

    task automatic check_reset_flags();
        chk("rst_valid", {127'd0, o_valid}, 128'd0);
        chk("rst_full", {127'd0, o_full}, 128'd0);
        chk("rst_ready", {127'd0, o_ready}, 128'd1);
        chk("rst_ovf", {120'd0, o_ovf}, 128'd0);
        chk("rst_udf", {127'd0, o_udf}, 128'd0);
    endtask

    function automatic logic [W*C-1:0] rand_row();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        logic [W*C-1:0] d;
        n_chk  = 0;
        n_pass = 0;
        wr_v   = '0;
        din_v  = '0;
        rd_v   = 1'b0;
        reset_n = 1'b0;
        model_clear();
        #2;
        check_reset_flags();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // 1: one lane per cycle; row only valid once lane 7 lands
        for (int g = 0; g < C; g++) begin
            d = '0;
            d[W*g +: W] = 16'h0100 + 16'(g);
            do_cycle(8'(1 << g), d, 1'b0);
        end
        d = '0;
        for (int g = 0; g < C; g++) d[W*g +: W] = 16'h0200 + 16'(g);
        do_cycle(8'hFF, d, 1'b0);

        // 2: two pops drain both rows, no underflow
        do_cycle(8'h00, '0, 1'b1);
        do_cycle(8'h00, '0, 1'b1);
        do_cycle(8'h00, '0, 1'b0);

        // 3: fill lane 3, overflow it, then complete rows and drain
        for (int i = 0; i < D + 1; i++) begin
            d = '0;
            d[W*3 +: W] = 16'h3000 + 16'(i);
            do_cycle(8'b0000_1000, d, 1'b0);
        end
        chk("ovf_lane3", {120'd0, o_ovf}, {120'd0, 8'b0000_1000});
        for (int i = 0; i < D; i++) do_cycle(8'hF7, rand_row(), 1'b0);
        for (int i = 0; i < D; i++) do_cycle(8'h00, '0, 1'b1);
        do_cycle(8'h00, '0, 1'b0);

        // 4: lane 5 empty -> rd underflows, nothing moves
        do_cycle(8'hDF, rand_row(), 1'b0);
        do_cycle(8'h00, '0, 1'b1);
        do_cycle(8'h00, '0, 1'b0);
        do_cycle(8'h20, rand_row(), 1'b0);
        do_cycle(8'h00, '0, 1'b1);
        chk("udf_sticky", {127'd0, o_udf}, 128'd1);

        reset_n = 1'b0;
        model_clear();
        #1;
        check_reset_flags();
        @(negedge clk);
        reset_n = 1'b1;

        // 5: 200 overlapped rows at half occupancy, wrapping pointers several times
        for (int i = 0; i < D / 2; i++) do_cycle(8'hFF, rand_row(), 1'b0);
        for (int i = 0; i < 200; i++) do_cycle(8'hFF, rand_row(), 1'b1);
        for (int i = 0; i < 5; i++) do_cycle(8'h00, '0, 1'b1);

        // 6: async reset between edges while data is queued
        #3;
        reset_n = 1'b0;
        #1;
        check_reset_flags();
        model_clear();
        @(negedge clk);
        reset_n = 1'b1;
        d = rand_row();
        do_cycle(8'hFF, d, 1'b0);
        chk("post_rst_row", out_v, d);
        do_cycle(8'h00, '0, 1'b1);
        do_cycle(8'h00, '0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
